// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller and its datapath.
package rv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWRITE = 4'd4,
        MEMWB    = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Only add/slt/or/and are implemented for R- and I-type ALU ops.
    function automatic logic funct3_alu_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and status in, datapath controls out, between controller and datapath.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, Illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp plus instruction function bits onto the ALU operation code.
module alu_decoder
    import rv_mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // ALU operation select; sub only for R-type with funct7b5 set.
    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alucontrol = ALUC_SLT;
                    3'b110:  alucontrol = ALUC_OR;
                    3'b111:  alucontrol = ALUC_AND;
                    default: alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the shared-memory multicycle RV32I datapath, with memory
// handshake stalls and a sticky trap on unsupported instructions.
module multicycle_controller
    import rv_mc_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    state_t     state_r;
    state_t     next_state_s;
    aluop_t     aluop_s;
    logic       pcupdate_s;
    logic       branch_s;
    logic       adrsrc_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       illegal_s;
    logic [1:0] resultsrc_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] immsrc_s;
    logic [2:0] alucontrol_s;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        next_state_s = state_r;
        aluop_s      = ALUOP_ADD;
        pcupdate_s   = 1'b0;
        branch_s     = 1'b0;
        adrsrc_s     = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        illegal_s    = 1'b0;
        resultsrc_s  = RES_ALUOUT;
        alusrca_s    = SRCA_PC;
        alusrcb_s    = SRCB_B;
        case (state_r)
            FETCH: begin
                alusrcb_s   = SRCB_FOUR;
                resultsrc_s = RES_ALURESULT;
                irwrite_s   = bus.MemReady;
                pcupdate_s  = bus.MemReady;
                next_state_s = bus.MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch/jump target is precomputed here into ALUOut.
                alusrca_s = SRCA_OLDPC;
                alusrcb_s = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: next_state_s = (bus.funct3 == 3'b010) ? MEMADR : TRAP;
                    OP_R:         next_state_s = funct3_alu_legal(bus.funct3) ? EXECR : TRAP;
                    OP_I:         next_state_s = funct3_alu_legal(bus.funct3) ? EXECI : TRAP;
                    OP_BEQ:       next_state_s = (bus.funct3 == 3'b000) ? BEQ : TRAP;
                    OP_JAL:       next_state_s = JAL;
                    default:      next_state_s = TRAP;
                endcase
            end
            MEMADR: begin
                alusrca_s    = SRCA_A;
                alusrcb_s    = SRCB_IMM;
                next_state_s = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrsrc_s     = 1'b1;
                next_state_s = bus.MemReady ? MEMWB : MEMREAD;
            end
            MEMWRITE: begin
                adrsrc_s     = 1'b1;
                memwrite_s   = 1'b1;
                next_state_s = bus.MemReady ? FETCH : MEMWRITE;
            end
            MEMWB: begin
                resultsrc_s  = RES_DATA;
                regwrite_s   = 1'b1;
                next_state_s = FETCH;
            end
            EXECR: begin
                alusrca_s    = SRCA_A;
                aluop_s      = ALUOP_FUNCT;
                next_state_s = ALUWB;
            end
            EXECI: begin
                alusrca_s    = SRCA_A;
                alusrcb_s    = SRCB_IMM;
                aluop_s      = ALUOP_FUNCT;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                regwrite_s   = 1'b1;
                next_state_s = FETCH;
            end
            BEQ: begin
                alusrca_s    = SRCA_A;
                aluop_s      = ALUOP_SUB;
                branch_s     = 1'b1;
                next_state_s = FETCH;
            end
            JAL: begin
                // PC <= target from ALUOut while ALU forms OldPC+4 for rd.
                alusrca_s    = SRCA_OLDPC;
                alusrcb_s    = SRCB_FOUR;
                pcupdate_s   = 1'b1;
                next_state_s = ALUWB;
            end
            TRAP: begin
                illegal_s    = 1'b1;
                next_state_s = TRAP;
            end
            default: next_state_s = FETCH;
        endcase
    end

    // Immediate format follows the opcode directly.
    always_comb begin
        immsrc_s = IMM_I;
        case (bus.op)
            OP_SW:   immsrc_s = IMM_S;
            OP_BEQ:  immsrc_s = IMM_B;
            OP_JAL:  immsrc_s = IMM_J;
            default: immsrc_s = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop_s),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (alucontrol_s)
    );

    assign bus.PCWrite    = pcupdate_s | (branch_s & bus.Zero);
    assign bus.AdrSrc     = adrsrc_s;
    assign bus.MemWrite   = memwrite_s;
    assign bus.IRWrite    = irwrite_s;
    assign bus.ResultSrc  = resultsrc_s;
    assign bus.ALUSrcA    = alusrca_s;
    assign bus.ALUSrcB    = alusrcb_s;
    assign bus.RegWrite   = regwrite_s;
    assign bus.ImmSrc     = immsrc_s;
    assign bus.ALUControl = alucontrol_s;
    assign bus.Illegal    = illegal_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: a per-instruction phase plan predicts every cycle's controls.
module tb_multicycle_controller;

    typedef enum int {P_FETCH, P_DECODE, P_ADDR, P_READ, P_WRITE, P_LOADWB,
                      P_EXR, P_EXI, P_WB, P_BRANCH, P_JUMP, P_TRAP} ph_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    ph_t  plan[$];

    // Statistics observed on the DUT during the last run_instr.
    int         st_cycles, st_rw, st_mw, st_ir, st_pcw, st_rw_cyc, st_ir_cyc;
    logic [2:0] st_exec_alu;

    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [16:0] dut_vec();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.ALUControl, bus.Illegal};
    endfunction

    // Expected controls for one cycle of the given phase.
    function automatic logic [16:0] model(input ph_t ph, input logic mr, input logic zero,
                                          input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, ir = 1'b0, rw = 1'b0, ill = 1'b0;
        logic [1:0] res = 2'd0, a = 2'd0, b = 2'd0, imm = 2'd0;
        logic [2:0] alu = 3'd0;
        if (op == SW) imm = 2'd1;
        else if (op == BR) imm = 2'd2;
        else if (op == JL) imm = 2'd3;
        case (ph)
            P_FETCH:  begin pcw = mr; ir = mr; res = 2'd2; b = 2'd2; end
            P_DECODE: begin a = 2'd1; b = 2'd1; end
            P_ADDR:   begin a = 2'd2; b = 2'd1; end
            P_READ:   adr = 1'b1;
            P_WRITE:  begin adr = 1'b1; mw = 1'b1; end
            P_LOADWB: begin res = 2'd1; rw = 1'b1; end
            P_EXR, P_EXI: begin
                a = 2'd2;
                b = (ph == P_EXI) ? 2'd1 : 2'd0;
                if (f3 == 3'd0)      alu = (op[5] && f7) ? 3'd1 : 3'd0;
                else if (f3 == 3'd2) alu = 3'd5;
                else if (f3 == 3'd6) alu = 3'd3;
                else if (f3 == 3'd7) alu = 3'd2;
            end
            P_WB:     rw = 1'b1;
            P_BRANCH: begin a = 2'd2; alu = 3'd1; pcw = zero; end
            P_JUMP:   begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
            P_TRAP:   ill = 1'b1;
            default:  ill = 1'b0;
        endcase
        return {pcw, adr, mw, ir, res, a, b, rw, imm, alu, ill};
    endfunction

    // Sequence of phases the instruction must walk through.
    task automatic make_plan(input logic [6:0] op, input logic [2:0] f3);
        bit alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        plan = '{P_FETCH, P_DECODE};
        if (op == LW && f3 == 3'd2)      begin plan.push_back(P_ADDR); plan.push_back(P_READ); plan.push_back(P_LOADWB); end
        else if (op == SW && f3 == 3'd2) begin plan.push_back(P_ADDR); plan.push_back(P_WRITE); end
        else if (op == RT && alu_ok)     begin plan.push_back(P_EXR); plan.push_back(P_WB); end
        else if (op == IT && alu_ok)     begin plan.push_back(P_EXI); plan.push_back(P_WB); end
        else if (op == BR && f3 == 3'd0) plan.push_back(P_BRANCH);
        else if (op == JL)               begin plan.push_back(P_JUMP); plan.push_back(P_WB); end
        else                             plan.push_back(P_TRAP);
    endtask

    // Drives one instruction; fstall/mstall < 0 means a random number of wait cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int fstall, input int mstall, input int zmode);
        logic [16:0] got, exp;
        make_plan(op, f3);
        st_cycles = 0; st_rw = 0; st_mw = 0; st_ir = 0; st_pcw = 0;
        st_rw_cyc = 0; st_ir_cyc = 0; st_exec_alu = 3'bxxx;
        foreach (plan[p]) begin
            int n = 0;
            if (plan[p] == P_FETCH) n = (fstall < 0) ? int'($urandom_range(0, 2)) : fstall;
            if (plan[p] == P_READ || plan[p] == P_WRITE) n = (mstall < 0) ? int'($urandom_range(0, 2)) : mstall;
            for (int k = 0; k <= n; k++) begin
                @(negedge clk);
                bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
                bus.Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
                if (plan[p] == P_FETCH || plan[p] == P_READ || plan[p] == P_WRITE)
                    bus.MemReady = (k == n);
                else
                    bus.MemReady = 1'($urandom);
                #1;
                st_cycles++;
                got = dut_vec();
                exp = model(plan[p], bus.MemReady, bus.Zero, op, f3, f7);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL ctrl %s op=%b f3=%0d cyc%0d: got %h expected %h",
                             plan[p].name(), op, f3, st_cycles, got, exp);
                end
                if (bus.RegWrite === 1'b1) begin st_rw++; if (st_rw_cyc == 0) st_rw_cyc = st_cycles; end
                if (bus.IRWrite === 1'b1)  begin st_ir++; if (st_ir_cyc == 0) st_ir_cyc = st_cycles; end
                if (bus.MemWrite === 1'b1) st_mw++;
                if (bus.PCWrite === 1'b1)  st_pcw++;
                if (plan[p] == P_EXR || plan[p] == P_EXI) st_exec_alu = bus.ALUControl;
            end
        end
    endtask

    task automatic pulse_reset_and_check(input string tag);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; bus.MemReady = 1'b0; #1;
        n_checks++;
        if (bus.Illegal !== 1'b0 || bus.ALUSrcB !== 2'b10 || bus.ResultSrc !== 2'b10 || bus.IRWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got Illegal=%b SrcB=%b Res=%b IR=%b expected 0/10/10/0",
                     tag, bus.Illegal, bus.ALUSrcB, bus.ResultSrc, bus.IRWrite);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.op = LW; bus.funct3 = 3'd2; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.MemReady = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (dut_vec() !== model(P_FETCH, 1'b1, 1'b0, LW, 3'd2, 1'b0)) begin
            n_fail++; $display("FAIL reset_fetch_ready: got %h expected %h", dut_vec(), model(P_FETCH, 1'b1, 1'b0, LW, 3'd2, 1'b0));
        end
        bus.MemReady = 1'b0; #1;
        n_checks++;
        if (dut_vec() !== model(P_FETCH, 1'b0, 1'b0, LW, 3'd2, 1'b0)) begin
            n_fail++; $display("FAIL reset_fetch_wait: got %h expected %h", dut_vec(), model(P_FETCH, 1'b0, 1'b0, LW, 3'd2, 1'b0));
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(LW, 3'd2, 1'b0, 0, 0, 2);
        n_checks++;
        if (st_cycles !== 5 || st_rw !== 1 || st_rw_cyc !== 5 || st_ir !== 1 || st_ir_cyc !== 1) begin
            n_fail++;
            $display("FAIL lw_timing: got cyc=%0d rw=%0d@%0d ir=%0d@%0d expected 5 1@5 1@1",
                     st_cycles, st_rw, st_rw_cyc, st_ir, st_ir_cyc);
        end
    endtask

    task automatic test_sw_stall();
        run_instr(SW, 3'd2, 1'b0, 0, 3, 2);
        n_checks++;
        if (st_mw !== 4 || st_rw !== 0 || st_cycles !== 7) begin
            n_fail++;
            $display("FAIL sw_stall: got mw=%0d rw=%0d cyc=%0d expected 4 0 7", st_mw, st_rw, st_cycles);
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops[4]  = '{RT, RT, IT, IT};
        logic [2:0] f3s[4]  = '{3'd0, 3'd0, 3'd0, 3'd7};
        logic       f7s[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] want[4] = '{3'b001, 3'b000, 3'b000, 3'b010};
        for (int i = 0; i < 4; i++) begin
            run_instr(ops[i], f3s[i], f7s[i], 0, 0, 2);
            n_checks++;
            if (st_exec_alu !== want[i] || st_rw !== 1 || st_cycles !== 4) begin
                n_fail++;
                $display("FAIL alu_op%0d: got alu=%b rw=%0d cyc=%0d expected %b 1 4",
                         i, st_exec_alu, st_rw, st_cycles, want[i]);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 0; z < 2; z++) begin
            run_instr(BR, 3'd0, 1'b0, 0, 0, z);
            n_checks++;
            if (st_pcw !== 1 + z || st_cycles !== 3) begin
                n_fail++;
                $display("FAIL beq_zero%0d: got pcw=%0d cyc=%0d expected %0d 3", z, st_pcw, st_cycles, 1 + z);
            end
        end
    endtask

    task automatic test_jal();
        run_instr(JL, 3'd5, 1'b1, 0, 0, 2);
        n_checks++;
        if (st_pcw !== 2 || st_rw !== 1 || st_rw_cyc !== 4 || st_cycles !== 4) begin
            n_fail++;
            $display("FAIL jal: got pcw=%0d rw=%0d@%0d cyc=%0d expected 2 1@4 4", st_pcw, st_rw, st_rw_cyc, st_cycles);
        end
    endtask

    task automatic test_illegal();
        run_instr(LUI, 3'd0, 1'b0, 0, 0, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.MemReady = 1'($urandom); bus.Zero = 1'($urandom); #1;
            n_checks++;
            if (bus.Illegal !== 1'b1 || {bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite} !== 4'b0000) begin
                n_fail++;
                $display("FAIL trap_hold%0d: got Illegal=%b en=%b expected 1 0000", i,
                         bus.Illegal, {bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite});
            end
        end
        pulse_reset_and_check("trap_reset");
    endtask

    task automatic test_reset_midaccess();
        run_instr(RT, 3'd6, 1'b0, 0, 0, 2);
        bus.op = LW; bus.funct3 = 3'd2;
        @(negedge clk); bus.MemReady = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.MemReady = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (bus.AdrSrc !== 1'b1 || bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL memread_stall: got Adr=%b RW=%b MW=%b expected 1 0 0", bus.AdrSrc, bus.RegWrite, bus.MemWrite);
        end
        pulse_reset_and_check("reset_in_memread");
    endtask

    task automatic test_random();
        logic [6:0] ops[7] = '{LW, SW, RT, IT, BR, JL, LUI};
        logic [2:0] alu_f3[4] = '{3'd0, 3'd2, 3'd6, 3'd7};
        for (int i = 0; i < 60; i++) begin
            int s = $urandom_range(0, 6);
            logic [6:0] op = ops[s];
            logic [2:0] f3;
            if (s == 2 || s == 3) f3 = alu_f3[$urandom_range(0, 3)];
            else if (s == 4)      f3 = 3'd0;
            else                  f3 = 3'd2;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            if ($urandom_range(0, 15) == 0) op = 7'($urandom);
            run_instr(op, f3, 1'($urandom), -1, -1, 2);
            if (plan[plan.size() - 1] == P_TRAP) pulse_reset_and_check("rand_trap_reset");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_alu_ops();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_midaccess();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
